// File: rtl/mio_seg_scan.sv
// mio_seg_scan: N-digit multiplexed seven-segment controller on the MIO bus.
//
// Three registers are reachable through a 2-bit address: DATA (one nibble per digit),
// MASK (decimal-point and blink masks) and CTRL (display enable, leading-zero blanking).
// Read data is registered. A free-running scan walks the digits one slot at a time.
// Each slot opens with a short all-off window so the previous digit's segments never
// ghost onto the next anode. The scan keeps running while the display is disabled.
//
// Ports
//   clk      in   1       system clock, rising edge
//   rst      in   1       synchronous active-high reset
//   addr     in   2       0 DATA, 1 MASK, 2 CTRL, 3 reserved
//   wr_en    in   1       single-cycle write strobe
//   wr_data  in   32      write data
//   rd_data  out  32      registered read data for addr
//   SEGMENT  out  8       active-low segments, bit7 dp, bits6..0 g..a
//   AN       out  DIGITS  active-low digit enables, bit 0 = rightmost digit

// Register file: storage, address decode and registered readback.
module mio_seg_scan_regs #(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            addr,
    input  logic                  wr_en,
    input  logic [31:0]           wr_data,
    output logic [4*DIGITS-1:0]   data,
    output logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     blink_mask,
    output logic                  disp_en,
    output logic                  lzb_en,
    output logic [31:0]           rd_data
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    logic [31:0] rd_mux;
    logic [7:0]  dp8;
    logic [7:0]  blink8;

    // Only a subset of wr_data bits lands in storage; the rest are ignored on purpose.
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data;

    // Readback is taken from the register contents before any same-cycle write,
    // so a simultaneous read and write of one address returns the old value.
    always_comb begin
        rd_mux = '0;
        dp8    = '0;
        blink8 = '0;
        dp8[DIGITS-1:0]    = dp_mask;
        blink8[DIGITS-1:0] = blink_mask;
        case (addr)
            ADDR_DATA: rd_mux[4*DIGITS-1:0] = data;
            ADDR_MASK: rd_mux[15:0]         = {blink8, dp8};
            ADDR_CTRL: rd_mux[1:0]          = {lzb_en, disp_en};
            default:   rd_mux               = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            dp_mask    <= '0;
            blink_mask <= '0;
            disp_en    <= 1'b1;
            lzb_en     <= 1'b0;
            rd_data    <= '0;
        end else begin
            rd_data <= rd_mux;
            if (wr_en) begin
                case (addr)
                    ADDR_DATA: data <= wr_data[4*DIGITS-1:0];
                    ADDR_MASK: begin
                        dp_mask    <= wr_data[DIGITS-1:0];
                        blink_mask <= wr_data[8 +: DIGITS];
                    end
                    ADDR_CTRL: begin
                        disp_en <= wr_data[0];
                        lzb_en  <= wr_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

module mio_seg_scan #(
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int BLINK_SCANS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [7:0]        SEGMENT,
    output logic [DIGITS-1:0] AN
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DIGITS);
    localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    // The slot timer counts down: timer value t corresponds to slot cycle
    // c = SCAN_DIV-1-t, so "c < BLANK_CYC" becomes "t > SLOT_LOAD-BLANK_CYC".
    localparam logic [CW-1:0] SLOT_LOAD  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_TH   = CW'(SCAN_DIV - 1 - BLANK_CYC);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    // Scans remaining before the blink phase flips, also counted down.
    localparam logic [BW-1:0] SCAN_LOAD  = BW'(BLINK_SCANS - 1);

    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   blink_mask;
    logic                disp_en;
    logic                lzb_en;

    logic [CW-1:0] slot_tmr;
    logic [DW-1:0] digit;
    logic [BW-1:0] scan_tmr;
    logic          blink_phase;

    logic [4*DIGITS-1:0] data_from_digit;
    logic [3:0]          nib;
    logic                in_blank;
    logic                zero_blank;
    logic                blink_blank;
    logic [7:0]          seg_next;
    logic [DIGITS-1:0]   an_next;

    mio_seg_scan_regs #(
        .DIGITS (DIGITS)
    ) u_regs (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .data       (data),
        .dp_mask    (dp_mask),
        .blink_mask (blink_mask),
        .disp_en    (disp_en),
        .lzb_en     (lzb_en),
        .rd_data    (rd_data)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan sequencing: slot timer -> digit index -> full-scan count -> blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_tmr    <= SLOT_LOAD;
            digit       <= '0;
            scan_tmr    <= SCAN_LOAD;
            blink_phase <= 1'b0;
        end else if (slot_tmr == '0) begin
            slot_tmr <= SLOT_LOAD;
            if (digit == LAST_DIGIT) begin
                digit <= '0;
                if (scan_tmr == '0) begin
                    scan_tmr    <= SCAN_LOAD;
                    blink_phase <= ~blink_phase;
                end else begin
                    scan_tmr <= scan_tmr - 1'b1;
                end
            end else begin
                digit <= digit + 1'b1;
            end
        end else begin
            slot_tmr <= slot_tmr - 1'b1;
        end
    end

    // Shifting DATA down to the current digit serves both the nibble select and the
    // "this digit and everything to its left is zero" test for leading-zero blanking.
    always_comb begin
        data_from_digit = data >> {digit, 2'b00};
        nib             = data_from_digit[3:0];
        in_blank        = (slot_tmr > BLANK_TH);
        zero_blank      = lzb_en && (digit != '0) && (data_from_digit == '0);
        blink_blank     = blink_mask[digit] && blink_phase;
        an_next         = ~(DIGITS'(1) << digit);
        seg_next        = {~dp_mask[digit], hex7(nib)};
        if (zero_blank || blink_blank) begin
            seg_next = 8'hFF;
        end
        if (in_blank || !disp_en) begin
            an_next  = '1;
            seg_next = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN      <= '1;
            SEGMENT <= 8'hFF;
        end else begin
            AN      <= an_next;
            SEGMENT <= seg_next;
        end
    end

endmodule

// File: tb/tb_mio_seg_scan.sv
module tb_mio_seg_scan;

    localparam int DIGITS      = 4;
    localparam int SCAN_DIV    = 4;
    localparam int BLANK_CYC   = 1;
    localparam int BLINK_SCANS = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        addr = 2'd0;
    logic              wr_en = 1'b0;
    logic [31:0]       wr_data = '0;
    logic [31:0]       rd_data;
    logic [7:0]        SEGMENT;
    logic [DIGITS-1:0] AN;

    mio_seg_scan #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .BLINK_SCANS (BLINK_SCANS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .SEGMENT (SEGMENT),
        .AN      (AN)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents plus the number of scan cycles since reset.
    int          m_n;
    logic [31:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blink;
    logic        m_en;
    logic        m_lzb;
    logic [31:0] exp_rd;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic [7:0]  hex_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: return m_data;
            2'd1: return {20'd0, m_blink, 4'd0, m_dp};
            2'd2: return {30'd0, m_lzb, m_en};
            default: return 32'd0;
        endcase
    endfunction

    // Expected outputs after the next edge, from the cycle count and registers now.
    task automatic model_outputs();
        int c, d, scans, phase;
        logic [31:0] upper;
        logic [3:0]  nib;
        bit          blank;
        c     = m_n % SCAN_DIV;
        d     = (m_n / SCAN_DIV) % DIGITS;
        scans = m_n / (SCAN_DIV * DIGITS);
        phase = (scans / BLINK_SCANS) % 2;
        upper = m_data >> (4 * d);
        nib   = upper[3:0];
        if (!m_en || c < BLANK_CYC) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
        end else begin
            exp_an = ~(4'(1) << d);
            blank  = (m_blink[d] && phase == 1) || (m_lzb && d != 0 && upper == 0);
            if (blank) exp_seg = 8'hFF;
            else       exp_seg = {~m_dp[d], hex_tab[nib][6:0]};
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [1:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst     = r;
        wr_en   = we;
        addr    = a;
        wr_data = wd;
        if (r) begin
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
            exp_rd  = 32'd0;
            m_n     = 0;
            m_data  = 0;
            m_dp    = 0;
            m_blink = 0;
            m_en    = 1'b1;
            m_lzb   = 1'b0;
        end else begin
            exp_rd = model_read(a);
            model_outputs();
            if (we) begin
                case (a)
                    2'd0: m_data = wd & 32'h0000_FFFF;
                    2'd1: begin m_dp = wd[3:0]; m_blink = wd[11:8]; end
                    2'd2: begin m_en = wd[0]; m_lzb = wd[1]; end
                    default: ;
                endcase
            end
            m_n++;
        end
        @(posedge clk);
        #1;
        chk("AN", 32'(AN), 32'(exp_an));
        chk("SEGMENT", 32'(SEGMENT), 32'(exp_seg));
        chk("rd_data", rd_data, exp_rd);
    endtask

    task automatic idle(input int cycles, input logic [1:0] a);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, a, 32'd0);
    endtask

    initial begin
        hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

        // reset, then read CTRL
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd2, 32'd0);
        idle(2, 2'd2);

        step(1'b0, 1'b1, 2'd0, 32'h1234);
        idle(40, 2'd0);

        step(1'b0, 1'b1, 2'd0, 32'h0005);
        step(1'b0, 1'b1, 2'd2, 32'h3);
        idle(20, 2'd2);
        step(1'b0, 1'b1, 2'd0, 32'h0000);
        idle(20, 2'd0);
        step(1'b0, 1'b1, 2'd0, 32'hFFFF_0105);
        idle(20, 2'd0);

        step(1'b0, 1'b1, 2'd1, 32'h0000_0201);
        step(1'b0, 1'b1, 2'd0, 32'h0012);
        idle(140, 2'd1);

        step(1'b0, 1'b1, 2'd0, 32'h1234);
        step(1'b0, 1'b1, 2'd2, 32'h0);
        idle(20, 2'd0);
        step(1'b0, 1'b1, 2'd1, 32'h0000_0F0A);
        idle(3, 2'd1);

        // reset in the middle of a scan, display re-enabled first
        step(1'b0, 1'b1, 2'd2, 32'h1);
        idle(9, 2'd3);
        step(1'b1, 1'b0, 2'd0, 32'd0);
        idle(20, 2'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] wd;
            logic [1:0]  a;
            logic        we;
            logic        r;
            a  = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 599) == 0);
            wd = $urandom;
            if (a == 2'd0) wd = wd & {8{($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF}};
            if (a == 2'd2) wd[0] = ($urandom_range(0, 3) != 0);
            step(r, we, a, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
